tdm_slot_demux: RTL and testbench

- Receive-side counterpart of the 3-channel time-division slot multiplexer.
- Input is a serial TDM beat stream: a WIDTH-bit data bus plus a 3-bit active-low one-hot slot marker.
- Tracks slot phase with a sync state machine and rebuilds the three channel words in parallel registers.
- Publishes each complete good frame with a one-cycle strobe; sits between the input pins and downstream consumer logic.

---
 rtl/tdm_slot_demux.sv | 233 +++++++++++++++++++++++
 tb/tb_tdm_slot_demux.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_slot_demux.sv
// Receive-side demultiplexer for a 3-slot TDM beat stream: HUNT/TRACK/LOCKED sync FSM,
// per-slot shadow capture and one-strobe frame publish. Optional err_cnt output under SLOT_DEMUX_ERR_CNT_EN.
module tdm_slot_demux #(
    parameter int WIDTH       = 3,
    parameter int LOCK_FRAMES = 2,
    parameter int ERR_LIMIT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] data_in,
    input  logic [2:0]       slot_n_in,
    output logic [WIDTH-1:0] ch0_q,
    output logic [WIDTH-1:0] ch1_q,
    output logic [WIDTH-1:0] ch2_q,
    output logic             frame_valid,
    output logic             locked,
    output logic             slot_err
`ifdef SLOT_DEMUX_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [3:0] ERR_N  = 4'(ERR_LIMIT);

    state_t           state_q, state_d;
    logic [1:0]       exp_q, exp_d;
    logic [2:0]       frame_cnt_q, frame_cnt_d;
    logic [2:0]       miss_cnt_q, miss_cnt_d;
    logic             bad_q, bad_d;
    logic [WIDTH-1:0] shadow_q [3];
    logic [2:0]       shadow_wr;
    logic [WIDTH-1:0] ch0_d, ch1_d, ch2_d;
    logic             frame_valid_q, frame_valid_d;
    logic             slot_err_q, slot_err_d;
    logic             publish;

    logic             marker_ok;
    logic [1:0]       slot_idx;
    logic             match;
    logic             is_s0;
    logic [1:0]       exp_next;
    logic [3:0]       frame_inc;
    logic [3:0]       miss_inc;

    // Only a single low bit is a legal marker; idle and multi-low codes never match.
    always_comb begin
        marker_ok = 1'b1;
        slot_idx  = 2'd0;
        case (slot_n_in)
            3'b110:  slot_idx = 2'd0;
            3'b101:  slot_idx = 2'd1;
            3'b011:  slot_idx = 2'd2;
            default: marker_ok = 1'b0;
        endcase
    end

    assign match     = marker_ok && (slot_idx == exp_q);
    assign is_s0     = marker_ok && (slot_idx == 2'd0);
    assign exp_next  = (exp_q == 2'd2) ? 2'd0 : exp_q + 2'd1;
    assign frame_inc = {1'b0, frame_cnt_q} + 4'd1;
    assign miss_inc  = {1'b0, miss_cnt_q} + 4'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                ST_HUNT: begin
                    if (is_s0) state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (!match)
                        state_d = ST_HUNT;
                    else if (exp_q == 2'd2 && frame_inc == LOCK_N)
                        state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (!match && miss_inc >= ERR_N) state_d = ST_HUNT;
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Output logic
    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

    // Datapath next values; the slot2 word is published straight from data_in.
    always_comb begin
        exp_d         = exp_q;
        frame_cnt_d   = frame_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        bad_d         = bad_q;
        shadow_wr     = 3'b000;
        publish       = 1'b0;
        slot_err_d    = 1'b0;
        frame_valid_d = 1'b0;
        ch0_d         = ch0_q;
        ch1_d         = ch1_q;
        ch2_d         = ch2_q;
        if (ena) begin
            case (state_q)
                ST_HUNT: begin
                    if (is_s0) begin
                        shadow_wr[0] = 1'b1;
                        exp_d        = 2'd1;
                        frame_cnt_d  = 3'd0;
                        miss_cnt_d   = 3'd0;
                        bad_d        = 1'b0;
                    end
                end
                ST_TRACK: begin
                    if (match) begin
                        shadow_wr[exp_q] = 1'b1;
                        exp_d            = exp_next;
                        if (exp_q == 2'd2) begin
                            frame_cnt_d = frame_inc[2:0];
                            if (frame_inc == LOCK_N) begin
                                publish    = 1'b1;
                                bad_d      = 1'b0;
                                miss_cnt_d = 3'd0;
                            end
                        end
                    end else begin
                        exp_d       = 2'd0;
                        frame_cnt_d = 3'd0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the expected slot keeps advancing even on a bad beat.
                    exp_d = exp_next;
                    if (match) begin
                        shadow_wr[exp_q] = 1'b1;
                        miss_cnt_d       = 3'd0;
                        bad_d            = (exp_q == 2'd0) ? 1'b0 : bad_q;
                        if (exp_q == 2'd2 && !bad_q) publish = 1'b1;
                    end else begin
                        slot_err_d = 1'b1;
                        bad_d      = 1'b1;
                        miss_cnt_d = miss_inc[2:0];
                        if (miss_inc >= ERR_N) begin
                            miss_cnt_d  = 3'd0;
                            exp_d       = 2'd0;
                            frame_cnt_d = 3'd0;
                            bad_d       = 1'b0;
                        end
                    end
                end
                default: begin
                    exp_d = 2'd0;
                end
            endcase
        end
        if (publish) begin
            frame_valid_d = 1'b1;
            ch0_d         = shadow_q[0];
            ch1_d         = shadow_q[1];
            ch2_d         = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q         <= 2'd0;
            frame_cnt_q   <= 3'd0;
            miss_cnt_q    <= 3'd0;
            bad_q         <= 1'b0;
            ch0_q         <= '0;
            ch1_q         <= '0;
            ch2_q         <= '0;
            frame_valid_q <= 1'b0;
            slot_err_q    <= 1'b0;
            for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
        end else begin
            exp_q         <= exp_d;
            frame_cnt_q   <= frame_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            bad_q         <= bad_d;
            ch0_q         <= ch0_d;
            ch1_q         <= ch1_d;
            ch2_q         <= ch2_d;
            frame_valid_q <= frame_valid_d;
            slot_err_q    <= slot_err_d;
            for (int i = 0; i < 3; i++) begin
                if (shadow_wr[i]) shadow_q[i] <= data_in;
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign slot_err    = slot_err_q;

`ifdef SLOT_DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturates at 255; only rst_n clears it.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (slot_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_slot_demux.sv
// Directed bench for tdm_slot_demux: per-beat flag checks plus a frame scoreboard for published words.
module tb_tdm_slot_demux;

    localparam logic [2:0] S0   = 3'b110;
    localparam logic [2:0] S1   = 3'b101;
    localparam logic [2:0] S2   = 3'b011;
    localparam logic [2:0] IDLE = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [2:0] data_in = '0;
    logic [2:0] slot_n_in = IDLE;
    logic [2:0] ch0_q, ch1_q, ch2_q;
    logic       frame_valid, locked, slot_err;
`ifdef SLOT_DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt;
    int         err_model = 0;
`endif

    int         tests = 0;
    int         fails = 0;
    logic [8:0] sb[$];
    logic [8:0] last = '0;

    tdm_slot_demux #(.WIDTH(3), .LOCK_FRAMES(2), .ERR_LIMIT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .data_in     (data_in),
        .slot_n_in   (slot_n_in),
        .ch0_q       (ch0_q),
        .ch1_q       (ch1_q),
        .ch2_q       (ch2_q),
        .frame_valid (frame_valid),
        .locked      (locked),
        .slot_err    (slot_err)
`ifdef SLOT_DEMUX_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_words(input string tag);
        chk({tag, ".ch0"}, {5'd0, ch0_q}, {5'd0, last[8:6]});
        chk({tag, ".ch1"}, {5'd0, ch1_q}, {5'd0, last[5:3]});
        chk({tag, ".ch2"}, {5'd0, ch2_q}, {5'd0, last[2:0]});
    endtask

    // One clock with the given beat; outputs sampled 1ns after the edge.
    task automatic send(input logic en, input logic [2:0] m, input logic [2:0] d,
                        input logic fv, input logic er, input logic lk);
        ena       = en;
        slot_n_in = m;
        data_in   = d;
        @(posedge clk);
        #1;
        chk("frame_valid", {7'd0, frame_valid}, {7'd0, fv});
        chk("slot_err", {7'd0, slot_err}, {7'd0, er});
        chk("locked", {7'd0, locked}, {7'd0, lk});
        if (fv) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL scoreboard: observed empty queue expected a pending frame");
            end
            if (sb.size() != 0) last = sb.pop_front();
        end
        chk_words("beat");
`ifdef SLOT_DEMUX_ERR_CNT_EN
        if (er && err_model != 255) err_model++;
        chk("err_cnt", err_cnt, 8'(err_model));
`endif
    endtask

    task automatic frame(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                         input logic pub, input logic lk0, input logic lk2);
        send(1'b1, S0, a, 1'b0, 1'b0, lk0);
        send(1'b1, S1, b, 1'b0, 1'b0, lk0);
        if (pub) sb.push_back({a, b, c});
        send(1'b1, S2, c, pub, 1'b0, lk2);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".frame_valid"}, {7'd0, frame_valid}, 8'd0);
        chk({tag, ".slot_err"}, {7'd0, slot_err}, 8'd0);
        chk({tag, ".locked"}, {7'd0, locked}, 8'd0);
        chk_words(tag);
`ifdef SLOT_DEMUX_ERR_CNT_EN
        chk({tag, ".err_cnt"}, err_cnt, 8'd0);
`endif
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // Clean lock: publish on slot2 of frame 2, then every frame
        frame(3'd5, 3'd2, 3'd7, 1'b0, 1'b0, 1'b0);
        frame(3'd5, 3'd2, 3'd7, 1'b1, 1'b0, 1'b1);
        frame(3'd5, 3'd2, 3'd7, 1'b1, 1'b1, 1'b1);
        frame(3'd1, 3'd4, 3'd6, 1'b1, 1'b1, 1'b1);

        // Single invalid marker: flywheel, frame dropped, lock kept
        send(1'b1, S0,   3'd3, 1'b0, 1'b0, 1'b1);
        send(1'b1, IDLE, 3'd3, 1'b0, 1'b1, 1'b1);
        send(1'b1, S2,   3'd3, 1'b0, 1'b0, 1'b1);
        frame(3'd6, 3'd1, 3'd4, 1'b1, 1'b1, 1'b1);

        // Loss of lock: slot0 repeated where slot1 and slot2 were expected
        send(1'b1, S0, 3'd1, 1'b0, 1'b0, 1'b1);
        send(1'b1, S0, 3'd1, 1'b0, 1'b1, 1'b1);
        send(1'b1, S0, 3'd1, 1'b0, 1'b1, 1'b0);
        send(1'b1, S1, 3'd1, 1'b0, 1'b0, 1'b0);
        send(1'b1, S2, 3'd1, 1'b0, 1'b0, 1'b0);
        frame(3'd2, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0);
        frame(3'd7, 3'd7, 3'd1, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset right after a slot1 beat
        send(1'b1, S0, 3'd4, 1'b0, 1'b0, 1'b1);
        send(1'b1, S1, 3'd4, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        last = '0;
`ifdef SLOT_DEMUX_ERR_CNT_EN
        err_model = 0;
`endif
        chk_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        send(1'b1, S2, 3'd4, 1'b0, 1'b0, 1'b0);
        // Constant slot0 (transmitter in reset): HUNT/TRACK oscillation, never publishes
        for (int i = 0; i < 6; i++) send(1'b1, S0, 3'(i), 1'b0, 1'b0, 1'b0);
        send(1'b1, S1, 3'd0, 1'b0, 1'b0, 1'b0);
        send(1'b1, S2, 3'd0, 1'b0, 1'b0, 1'b0);
        frame(3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
        frame(3'd4, 3'd5, 3'd6, 1'b1, 1'b0, 1'b1);

        // ena gating mid-frame: misleading markers must be ignored
        send(1'b1, S0, 3'd2, 1'b0, 1'b0, 1'b1);
        send(1'b1, S1, 3'd6, 1'b0, 1'b0, 1'b1);
        send(1'b0, S0,   3'd7, 1'b0, 1'b0, 1'b1);
        send(1'b0, S0,   3'd7, 1'b0, 1'b0, 1'b1);
        send(1'b0, IDLE, 3'd0, 1'b0, 1'b0, 1'b1);
        send(1'b0, 3'b000, 3'd1, 1'b0, 1'b0, 1'b1);
        sb.push_back({3'd2, 3'd6, 3'd3});
        send(1'b1, S2, 3'd3, 1'b1, 1'b0, 1'b1);

`ifdef SLOT_DEMUX_ERR_CNT_EN
        // 300 invalid beats in bursts of two, relocking between bursts
        for (int b = 0; b < 150; b++) begin
            send(1'b1, IDLE, 3'd0, 1'b0, 1'b1, 1'b1);
            send(1'b1, IDLE, 3'd0, 1'b0, 1'b1, 1'b0);
            frame(3'(b), 3'(b + 1), 3'(b + 2), 1'b0, 1'b0, 1'b0);
            frame(3'(b + 3), 3'(b + 4), 3'(b + 5), 1'b1, 1'b0, 1'b1);
        end
        chk("err_cnt_saturated", err_cnt, 8'd255);
`endif

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: observed %0d pending frames expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
